// File: rtl/ldm_stm_sequencer.sv
// LDM/STM multi-register transfer sequencer driving the register file write and read-B ports.
// Optional base write-back stage (wback port, WB state) is compiled in with LDM_STM_WRITEBACK_EN.
module ldm_stm_sequencer #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned WORD_BYTES = 4
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              start,
  input  logic              load,
  input  logic              up,
  input  logic              pre,
  input  logic [3:0]        rn,
  input  logic [DATA_W-1:0] base,
  input  logic [15:0]       reg_list,
`ifdef LDM_STM_WRITEBACK_EN
  input  logic              wback,
`endif
  output logic [3:0]        rf_addrA,
  output logic [3:0]        rf_addrB,
  output logic              rf_RW,
  output logic [DATA_W-1:0] rf_data,
  input  logic [DATA_W-1:0] rf_outB,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
`ifdef LDM_STM_WRITEBACK_EN
    WB   = 2'd2,
`endif
    DONE = 2'd3
  } state_t;

  function automatic logic [4:0] popCount(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
    return n;
  endfunction

  function automatic logic [3:0] lowestSet(input logic [15:0] v);
    logic [3:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--) if (v[i]) r = 4'(i);
    return r;
  endfunction

  state_t            state, stateNext;
  logic              loadQ;
  logic [15:0]       listQ;
  logic [DATA_W-1:0] addrQ;
  logic [4:0]        cntQ;

  logic [4:0]        cntNew;
  logic [DATA_W-1:0] stepW;
  logic [DATA_W-1:0] spanNew;
  logic [DATA_W-1:0] startAddr;
  logic [15:0]       listLeft;
  logic [3:0]        idx;

  assign stepW    = DATA_W'(WORD_BYTES);
  assign cntNew   = popCount(reg_list);
  assign spanNew  = DATA_W'(cntNew) * stepW;
  assign listLeft = listQ & (listQ - 16'd1);
  assign idx      = lowestSet(listQ);
  assign mem_wdata = rf_outB;

  // First access address for the four IA/IB/DA/DB addressing modes
  always_comb begin
    unique case ({up, pre})
      2'b10:   startAddr = base;
      2'b11:   startAddr = base + stepW;
      2'b00:   startAddr = base - spanNew + stepW;
      default: startAddr = base - spanNew;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state <= IDLE;
      loadQ <= 1'b0;
      listQ <= '0;
      addrQ <= '0;
      cntQ  <= '0;
    end else begin
      state <= stateNext;
      if (state == IDLE && start) begin
        loadQ <= load;
        listQ <= reg_list;
        addrQ <= startAddr;
        cntQ  <= cntNew;
      end else if (state == XFER && mem_ready) begin
        listQ <= listLeft;
        addrQ <= addrQ + stepW;
      end
    end
  end

`ifdef LDM_STM_WRITEBACK_EN
  logic              upQ;
  logic              wbackQ;
  logic [3:0]        rnQ;
  logic [DATA_W-1:0] baseQ;
  logic [15:0]       origListQ;
  logic [DATA_W-1:0] finalBase;
  logic              wbActive;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      upQ       <= 1'b0;
      wbackQ    <= 1'b0;
      rnQ       <= '0;
      baseQ     <= '0;
      origListQ <= '0;
    end else if (state == IDLE && start) begin
      upQ       <= up;
      wbackQ    <= wback;
      rnQ       <= rn;
      baseQ     <= base;
      origListQ <= reg_list;
    end
  end

  assign finalBase = upQ ? baseQ + DATA_W'(cntQ) * stepW : baseQ - DATA_W'(cntQ) * stepW;
  // A loaded base register keeps the loaded value instead of the updated base
  assign wbActive  = wbackQ && !(loadQ && origListQ[rnQ]);
`else
  logic unusedNoWb;
  assign unusedNoWb = ^{rn, cntQ};
`endif

  always_comb begin
    stateNext = state;
    rf_addrA  = '0;
    rf_addrB  = '0;
    rf_RW     = 1'b1;
    rf_data   = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (reg_list == 16'd0) stateNext = DONE;
          else                   stateNext = XFER;
        end
      end
      XFER: begin
        mem_req  = 1'b1;
        mem_we   = ~loadQ;
        mem_addr = addrQ;
        rf_addrB = idx;
        if (mem_ready) begin
          if (loadQ) begin
            rf_RW    = 1'b0;
            rf_addrA = idx;
            rf_data  = mem_rdata;
          end
          if (listLeft == 16'd0) begin
`ifdef LDM_STM_WRITEBACK_EN
            stateNext = WB;
`else
            stateNext = DONE;
`endif
          end
        end
      end
`ifdef LDM_STM_WRITEBACK_EN
      WB: begin
        if (wbActive) begin
          rf_RW    = 1'b0;
          rf_addrA = rnQ;
          rf_data  = finalBase;
        end
        stateNext = DONE;
      end
`endif
      DONE: begin
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed scoreboard bench for ldm_stm_sequencer: expected accesses and register writes are
// queued before each operation and matched as the DUT produces them.
module tb_ldm_stm_sequencer;

`ifdef LDM_STM_WRITEBACK_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  rb;
    logic [31:0] wdata;
  } acc_t;

  typedef struct packed {
    logic [3:0]  ra;
    logic [31:0] data;
  } wr_t;

  logic        CLK = 1'b0;
  logic        CLR;
  logic        start, load, up, pre, wback;
  logic [3:0]  rn;
  logic [31:0] base;
  logic [15:0] reg_list;
  logic [3:0]  rf_addrA, rf_addrB;
  logic        rf_RW;
  logic [31:0] rf_data, rf_outB;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready;
  logic        busy, done;

  acc_t accQ[$];
  wr_t  wrQ[$];
  int   total = 0;
  int   bad = 0;
  logic [31:0] regs [16];

  always #5 CLK = ~CLK;

  ldm_stm_sequencer #(.DATA_W(32), .WORD_BYTES(4)) dut (
    .CLK(CLK), .CLR(CLR), .start(start), .load(load), .up(up), .pre(pre),
    .rn(rn), .base(base), .reg_list(reg_list),
`ifdef LDM_STM_WRITEBACK_EN
    .wback(wback),
`endif
    .rf_addrA(rf_addrA), .rf_addrB(rf_addrB), .rf_RW(rf_RW), .rf_data(rf_data),
    .rf_outB(rf_outB), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .done(done)
  );

  function automatic logic [31:0] initVal(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  function automatic logic [31:0] memVal(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Register file and memory models
  always @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      for (int i = 0; i < 16; i++) regs[i] <= initVal(i);
    end else if (rf_RW === 1'b0) begin
      regs[rf_addrA] <= rf_data;
    end
  end
  assign rf_outB   = regs[rf_addrB];
  assign mem_rdata = memVal(mem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic pushAcc(input logic we, input logic [31:0] a, input logic [3:0] rb, input logic [31:0] wd);
    acc_t e;
    e.we = we; e.addr = a; e.rb = rb; e.wdata = wd;
    accQ.push_back(e);
  endtask

  task automatic pushWr(input logic [3:0] ra, input logic [31:0] d);
    wr_t e;
    e.ra = ra; e.data = d;
    wrQ.push_back(e);
  endtask

  // Scoreboard: match completed accesses and register writes in order
  always @(negedge CLK) begin
    if (CLR === 1'b1) begin
      if (mem_req === 1'b1 && mem_ready === 1'b1) begin
        total++;
        assert (accQ.size() > 0) else begin
          bad++;
          $error("FAIL unexpected_access observed_addr=%0h expected=none", mem_addr);
        end
        if (accQ.size() > 0) begin
          acc_t e;
          e = accQ.pop_front();
          check("acc_we", 32'(mem_we), 32'(e.we));
          check("acc_addr", mem_addr, e.addr);
          check("acc_rb", 32'(rf_addrB), 32'(e.rb));
          if (e.we) check("acc_wdata", mem_wdata, e.wdata);
        end
      end
      if (rf_RW === 1'b0) begin
        total++;
        assert (wrQ.size() > 0) else begin
          bad++;
          $error("FAIL unexpected_rf_write observed_reg=%0d data=%0h expected=none", rf_addrA, rf_data);
        end
        if (wrQ.size() > 0) begin
          wr_t w;
          w = wrQ.pop_front();
          check("wr_reg", 32'(rf_addrA), 32'(w.ra));
          check("wr_data", rf_data, w.data);
        end
      end
    end
  end

  task automatic queuesEmpty(input string tag);
    check({tag, "_acc_left"}, 32'(accQ.size()), 32'd0);
    check({tag, "_wr_left"}, 32'(wrQ.size()), 32'd0);
    accQ.delete();
    wrQ.delete();
  endtask

  task automatic runOp(input string tag, input logic ld, input logic u, input logic p,
                       input logic [3:0] r, input logic [31:0] b, input logic [15:0] lst,
                       input logic wb, input int expDone, input int stallFrom, input int stallLen,
                       input logic [31:0] stallAddr, input logic [3:0] stallRb);
    bit seen;
    seen = 1'b0;
    load = ld; up = u; pre = p; rn = r; base = b; reg_list = lst; wback = wb;
    mem_ready = 1'b1;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    for (int c = 1; c <= expDone + 20; c++) begin
      mem_ready = !(c >= stallFrom && c < stallFrom + stallLen);
      @(negedge CLK);
      if (!mem_ready) begin
        check({tag, "_stall_addr"}, mem_addr, stallAddr);
        check({tag, "_stall_rb"}, 32'(rf_addrB), 32'(stallRb));
      end
      if (done === 1'b1) begin
        seen = 1'b1;
        check({tag, "_done_cycle"}, 32'(c), 32'(expDone));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd1);
      end
      @(posedge CLK); #1;
      if (seen) break;
    end
    mem_ready = 1'b1;
    total++;
    assert (seen) else begin
      bad++;
      $error("FAIL %s_timeout observed=no_done expected=done_by_cycle_%0d", tag, expDone);
    end
    @(negedge CLK);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_done_after"}, 32'(done), 32'd0);
    queuesEmpty(tag);
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_rf_RW"}, 32'(rf_RW), 32'd1);
    check({tag, "_rf_addrA"}, 32'(rf_addrA), 32'd0);
    check({tag, "_rf_addrB"}, 32'(rf_addrB), 32'd0);
    check({tag, "_rf_data"}, rf_data, 32'd0);
    check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    CLR = 1'b0; start = 1'b0; load = 1'b0; up = 1'b0; pre = 1'b0; wback = 1'b0;
    rn = '0; base = '0; reg_list = '0; mem_ready = 1'b1;
    #12;
    checkResetOutputs("reset");
    @(posedge CLK); #1;
    CLR = 1'b1;
    @(posedge CLK); #1;

    // STMIA R0, {R0-R3}
    for (int i = 0; i < 4; i++) pushAcc(1'b1, 32'h100 + 32'(4 * i), 4'(i), initVal(i));
    runOp("stmia", 1'b0, 1'b1, 1'b0, 4'd0, 32'h100, 16'h000F, 1'b0, 5 + EXTRA, 0, 0, '0, '0);

    // LDMDB R13!, {R0, R1, R15}
    pushAcc(1'b0, 32'h1F4, 4'd0, '0);
    pushAcc(1'b0, 32'h1F8, 4'd1, '0);
    pushAcc(1'b0, 32'h1FC, 4'd15, '0);
    pushWr(4'd0, memVal(32'h1F4));
    pushWr(4'd1, memVal(32'h1F8));
    pushWr(4'd15, memVal(32'h1FC));
`ifdef LDM_STM_WRITEBACK_EN
    pushWr(4'd13, 32'h1F4);
`endif
    runOp("ldmdb", 1'b1, 1'b0, 1'b1, 4'd13, 32'h200, 16'h8003, 1'b1, 4 + EXTRA, 0, 0, '0, '0);

    // Empty register list
    runOp("empty", 1'b1, 1'b1, 1'b0, 4'd5, 32'h700, 16'h0000, 1'b1, 1, 0, 0, '0, '0);

    // STMIB with a 3-cycle stall on the second access
    pushAcc(1'b1, 32'h304, 4'd3, initVal(3));
    pushAcc(1'b1, 32'h308, 4'd4, initVal(4));
    pushAcc(1'b1, 32'h30C, 4'd7, initVal(7));
    runOp("stmib_stall", 1'b0, 1'b1, 1'b1, 4'd6, 32'h300, 16'h0098, 1'b0, 7 + EXTRA, 2, 3,
          32'h308, 4'd4);

    // LDMIA R2!, {R2}: loaded value wins over base write-back
    pushAcc(1'b0, 32'h400, 4'd2, '0);
    pushWr(4'd2, memVal(32'h400));
    runOp("ldmia_rn", 1'b1, 1'b1, 1'b0, 4'd2, 32'h400, 16'h0004, 1'b1, 2 + EXTRA, 0, 0, '0, '0);

    // Reset during the second of four load transfers
    pushAcc(1'b0, 32'h500, 4'd4, '0);
    pushWr(4'd4, memVal(32'h500));
    load = 1'b1; up = 1'b1; pre = 1'b0; rn = 4'd9; base = 32'h500; reg_list = 16'h00F0;
    wback = 1'b1; mem_ready = 1'b1; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    @(posedge CLK); #2;
    CLR = 1'b0;
    #1;
    checkResetOutputs("midreset");
    repeat (2) @(posedge CLK);
    #1;
    CLR = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      check("post_reset_idle_busy", 32'(busy), 32'd0);
    end
    @(posedge CLK); #1;
    queuesEmpty("midreset");

    // Start accepted normally after reset release
    pushAcc(1'b1, 32'h600, 4'd8, initVal(8));
    runOp("after_reset", 1'b0, 1'b1, 1'b0, 4'd1, 32'h600, 16'h0100, 1'b0, 2 + EXTRA, 0, 0, '0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ldm_stm_sequencer.md
Name: ldm_stm_sequencer

Overview:
- Multi-register transfer sequencer for LDM/STM instructions.
- Sits directly upstream of the 16x32 register file and drives its write port (addressA, inputData, RW) and read-B port (addressB).
- Walks a 16-bit register list, generates one word-aligned memory access per set bit, moves data between memory and the register file, and optionally writes back the updated base.

Parameters:
- DATA_W, 32, data and address width.
- WORD_BYTES, 4, address step per transferred register.

Ports:
- CLK  input  1  clock; all state changes on the positive edge.
- CLR  input  1  asynchronous active-low reset (clear=0, notClear=1).
- start  input  1  one-cycle request; sampled only in IDLE.
- load  input  1  1=LDM (memory to registers), 0=STM (registers to memory).
- up  input  1  U bit: 1=increment, 0=decrement.
- pre  input  1  P bit: 1=before, 0=after.
- rn  input  4  base register index.
- base  input  DATA_W  base address value (value of Rn).
- reg_list  input  16  register list; bit i means Ri.
- rf_addrA  output  4  register file write address.
- rf_addrB  output  4  register file read-B address.
- rf_RW  output  1  register file control: 1=read, 0=write.
- rf_data  output  DATA_W  register file write data.
- rf_outB  input  DATA_W  register file outB, used as store data.
- mem_req  output  1  memory access valid.
- mem_we  output  1  1=write (STM).
- mem_addr  output  DATA_W  access address.
- mem_wdata  output  DATA_W  store data; equals rf_outB.
- mem_rdata  input  DATA_W  load data.
- mem_ready  input  1  access completes in the cycle it is high while mem_req=1.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (CLR=0, asynchronous):
  - State IDLE; all internal registers cleared.
  - Outputs: rf_RW=1, rf_addrA=0, rf_addrB=0, rf_data=0, mem_req=0, mem_we=0, mem_addr=0, busy=0, done=0.
  - Reset mid-operation abandons the transfer; no further register file writes and no base write-back.
- States: IDLE, XFER, WB, DONE.
- IDLE:
  - On start=1, latch load, up, pre, rn, base and reg_list.
  - Compute cnt = popcount(reg_list), 0..16, held in a 5-bit register.
  - If reg_list=0, go to DONE. Otherwise go to XFER.
  - start is ignored in every other state.
- Start address (DATA_W-bit arithmetic, wrap modulo 2^DATA_W):
  - IA (up=1, pre=0): base.
  - IB (up=1, pre=1): base+4.
  - DA (up=0, pre=0): base-4*cnt+4.
  - DB (up=0, pre=1): base-4*cnt.
- Final base: up ? base+4*cnt : base-4*cnt.
- XFER:
  - idx is the lowest set bit of the remaining list; transfers always run in ascending register order.
  - Drive mem_req=1, mem_we=~load, mem_addr=current address, rf_addrB=idx.
  - When load=1 and mem_ready=1 (combinational):
    - rf_RW=0, rf_addrA=idx, rf_data=mem_rdata for that cycle only.
    - The register file captures the write on that clock edge.
  - On the mem_ready=1 edge: clear bit idx and add 4 to the current address.
  - When the remaining list becomes empty, go to WB if the feature is compiled in, else DONE.
  - If mem_ready stays low, remain in XFER with all outputs stable.
- WB: see Optional Feature; lasts one cycle, then DONE.
- DONE: done=1 for one cycle, busy still 1, then IDLE.
- Outside an active write cycle, rf_RW=1.
- Latency with mem_ready tied high, start at edge 0 and N set bits:
  - mem_req high in cycles 1..N.
  - done in cycle N+2 with the feature, N+1 without.
  - Empty list: done in cycle 1.

Optional Feature:
- Macro: LDM_STM_WRITEBACK_EN.
- Defined:
  - Adds input wback (W bit), latched at start.
  - In WB, if wback=1, drive rf_RW=0, rf_addrA=rn, rf_data=final base for one cycle.
  - If load=1 and bit rn was set in the latched list, the write-back is suppressed (loaded value wins), but the WB cycle still occurs.
  - If wback=0, the WB cycle occurs with rf_RW=1.
- Undefined: no wback port, no WB state; XFER goes directly to DONE.

Test Plan:
- STMIA, rn=0, base=0x100, reg_list=0x000F, mem_ready=1 -> mem_we=1 accesses at 0x100, 0x104, 0x108, 0x10C with rf_addrB=0,1,2,3; mem_wdata tracks rf_outB; rf_RW stays 1; done at cycle 6 (feature on).
- LDMDB, base=0x200, reg_list=0x8003 -> reads at 0x1F4, 0x1F8, 0x1FC; writes to R0, R1, R15 in that order with data = mem_rdata; with wback=1, R13 (rn=13) receives 0x1F4.
- reg_list=0x0000, start=1 -> no mem_req; done high exactly at cycle 1; busy high one cycle.
- STMIB with mem_ready low for 3 cycles on the 2nd access -> mem_addr and rf_addrB held stable during the stall; transfer order unchanged; done delayed by 3 cycles.
- LDMIA, rn=2, reg_list=0x0004, wback=1 -> R2 gets the loaded word; no base write in WB (rf_RW=1).
- CLR=0 asserted during the 2nd of 4 transfers -> outputs immediately at reset values; no further rf_RW=0 cycles; start accepted normally after release.
